// File: rtl/vdp_bus_bridge.sv
// rtl/vdp_bus_bridge.sv - CPU-to-VDP bridge: buffered write issue FSM plus register/VRAM read path
// Writes queue in a small FIFO and drain through a two-phase handshake; reads bypass the FIFO once it is drained.
module vdp_bus_bridge #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_cs,
  input  logic       cpu_rw,
  input  logic [1:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_rvalid,
  output logic       cpu_rdy,
  output logic [1:0] vdp_mode,
  output logic       vdp_write,
  output logic       vdp_read,
  output logic [7:0] vdp_wdata,
  input  logic [7:0] vdp_rdata,
  input  logic       vdp_rdy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            asrt2_q;
  logic [9:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic [1:0]      mode_q;
  logic [7:0]      wdata_q;
  logic            vdp_read_q, rd_cap_q;
  logic [7:0]      rdata_q;
  logic            rvalid_q;

  logic            full, empty, busy, rd_pend, is_stat;
  logic            accept, push, pop, data_rd, stat_rd;
  logic [4:0]      level_ext;
  logic [2:0]      level_sat;
  logic [7:0]      status;

  assign full      = (level_q == LW'(FIFO_DEPTH));
  assign empty     = (level_q == '0);
  assign rd_pend   = vdp_read_q | rd_cap_q;
  assign is_stat   = (cpu_addr == 2'd3);
  assign level_ext = 5'(level_q);
  assign level_sat = (level_ext > 5'd7) ? 3'd7 : level_ext[2:0];
  assign status    = {full, empty, busy, 2'b00, level_sat};

  always_comb begin
    cpu_rdy = 1'b0;
    if (cpu_rw && is_stat)      cpu_rdy = 1'b1;
    else if (cpu_rw)            cpu_rdy = empty && (state_q == ST_IDLE) && !rd_pend;
    else if (is_stat)           cpu_rdy = !rd_pend;
    else                        cpu_rdy = !full && !rd_pend;
  end

  assign accept  = cpu_cs && cpu_rdy;
  assign push    = accept && !cpu_rw && !is_stat;
  assign data_rd = accept && cpu_rw && !is_stat;
  assign stat_rd = accept && cpu_rw && is_stat;
  assign pop     = (state_q == ST_IDLE) && !empty;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cpu_addr, cpu_wdata};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      asrt2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      asrt2_q <= (state_q == ST_ASSERT) && (state_d == ST_ASSERT);
    end
  end

  // vdp_rdy only counts from the second ASSERT cycle, which gives the two-cycle minimum
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (!empty) state_d = ST_ASSERT;
      ST_ASSERT:  if (asrt2_q && vdp_rdy) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vdp_write = (state_q == ST_ASSERT);
    busy      = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= 2'd0;
      wdata_q    <= 8'd0;
      vdp_read_q <= 1'b0;
      rd_cap_q   <= 1'b0;
      rdata_q    <= 8'd0;
      rvalid_q   <= 1'b0;
    end else begin
      vdp_read_q <= data_rd;
      rd_cap_q   <= vdp_read_q;
      rvalid_q   <= vdp_read_q | stat_rd;
      if (pop)          {mode_q, wdata_q} <= mem_q[rd_ptr_q];
      else if (data_rd) mode_q <= cpu_addr;
      // a VDP read returning in the same cycle as a status read takes the data register
      if (vdp_read_q)   rdata_q <= vdp_rdata;
      else if (stat_rd) rdata_q <= status;
    end
  end

  assign vdp_mode   = mode_q;
  assign vdp_wdata  = wdata_q;
  assign vdp_read   = vdp_read_q;
  assign cpu_rdata  = rdata_q;
  assign cpu_rvalid = rvalid_q;
endmodule

// File: tb/tb_vdp_bus_bridge.sv
// tb/tb_vdp_bus_bridge.sv - directed self-checking bench for vdp_bus_bridge
// A one-cycle-lag VDP ready model answers vdp_write unless the bench stalls it.
module tb_vdp_bus_bridge;
  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_cs, cpu_rw;
  logic [1:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       cpu_rvalid, cpu_rdy;
  logic [1:0] vdp_mode;
  logic       vdp_write, vdp_read;
  logic [7:0] vdp_wdata, vdp_rdata;
  logic       vdp_rdy, vdp_stall;

  int n_assert = 0;
  int n_fail   = 0;

  vdp_bus_bridge #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_cs(cpu_cs), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_rdy(cpu_rdy),
    .vdp_mode(vdp_mode), .vdp_write(vdp_write), .vdp_read(vdp_read),
    .vdp_wdata(vdp_wdata), .vdp_rdata(vdp_rdata), .vdp_rdy(vdp_rdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) vdp_rdy <= reset ? 1'b0 : (vdp_write & ~vdp_stall);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Holds the request until accepted; returns in the cycle after the accepting edge.
  task automatic cpu_access(input logic rw, input logic [1:0] addr, input logic [7:0] data,
                            output int waited);
    waited    = 0;
    cpu_cs    = 1'b1;
    cpu_rw    = rw;
    cpu_addr  = addr;
    cpu_wdata = data;
    #1;
    while (!cpu_rdy && waited < 100) begin
      tick();
      waited++;
    end
    check("accept_timeout", {15'd0, cpu_rdy}, 16'd1);
    tick();
    cpu_cs = 1'b0;
  endtask

  initial begin
    int w;
    logic       ok;
    logic [7:0] exp_wr;
    logic [7:0] exp_d;
    logic [1:0] exp_m;

    reset = 1'b1; cpu_cs = 1'b0; cpu_rw = 1'b0; cpu_addr = 2'd0; cpu_wdata = 8'd0;
    vdp_rdata = 8'h00; vdp_stall = 1'b0;
    tick(); tick(); tick();
    check("rst_vdp_write", {15'd0, vdp_write}, 16'd0);
    check("rst_vdp_read",  {15'd0, vdp_read}, 16'd0);
    check("rst_vdp_mode",  {14'd0, vdp_mode}, 16'd0);
    check("rst_vdp_wdata", {8'd0, vdp_wdata}, 16'd0);
    check("rst_cpu_rdata", {8'd0, cpu_rdata}, 16'd0);
    check("rst_cpu_rvalid", {15'd0, cpu_rvalid}, 16'd0);
    check("rst_cpu_rdy",   {15'd0, cpu_rdy}, 16'd1);
    reset = 1'b0;
    tick();

    // Register select then register data: two issues separated by one RELEASE
    cpu_access(1'b0, 2'd0, 8'h04, w);
    cpu_access(1'b0, 2'd1, 8'h50, w);
    exp_wr = 8'b1100_1100;
    for (int i = 0; i < 8; i++) begin
      exp_m = (i < 4) ? 2'd0 : 2'd1;
      exp_d = (i < 4) ? 8'h04 : 8'h50;
      check($sformatf("issue_cyc%0d", i), {5'd0, vdp_write, vdp_mode, vdp_wdata},
            {5'd0, exp_wr[7-i], exp_m, exp_d});
      tick();
    end

    // VDP stalls for 10 ASSERT cycles
    vdp_stall = 1'b1;
    cpu_access(1'b0, 2'd2, 8'h11, w);
    tick();
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (vdp_write !== 1'b1) ok = 1'b0;
      tick();
    end
    check("stall_write_held", {15'd0, ok}, 16'd1);
    vdp_stall = 1'b0;
    tick();
    check("rdy_rise_rdy", {15'd0, vdp_rdy}, 16'd1);
    check("rdy_rise_write", {15'd0, vdp_write}, 16'd1);
    tick();
    check("release_cycle", {5'd0, vdp_write, vdp_mode, vdp_wdata}, {5'd0, 1'b0, 2'd2, 8'h11});
    tick();
    check("idle_after_release", {15'd0, vdp_write}, 16'd0);
    cpu_access(1'b1, 2'd3, 8'h00, w);
    check("status_idle", {7'd0, cpu_rvalid, cpu_rdata}, {7'd0, 1'b1, 8'h40});
    tick();
    check("rvalid_single", {15'd0, cpu_rvalid}, 16'd0);

    // Five VRAM writes against a stalled VDP fill the FIFO
    vdp_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cpu_access(1'b0, 2'd2, 8'hA0 + 8'(i), w);
      check($sformatf("fill_wait%0d", i), 16'(w), 16'd0);
    end
    cpu_rw = 1'b0; cpu_addr = 2'd2;
    #1;
    check("full_write_rdy", {15'd0, cpu_rdy}, 16'd0);
    cpu_access(1'b1, 2'd3, 8'h00, w);
    check("status_full", {7'd0, cpu_rvalid, cpu_rdata}, {7'd0, 1'b1, 8'hA4});
    check("head_in_assert", {5'd0, vdp_write, vdp_mode, vdp_wdata}, {5'd0, 1'b1, 2'd2, 8'hA0});
    vdp_stall = 1'b0;
    cpu_access(1'b0, 2'd2, 8'hA5, w);
    check("full_wait_cycles", 16'(w), 16'd4);
    for (int i = 0; i < 24; i++) tick();
    check("drain_last", {5'd0, vdp_write, vdp_mode, vdp_wdata}, {5'd0, 1'b0, 2'd2, 8'hA5});

    // VRAM read waits for two queued entries plus the one in flight
    vdp_rdata = 8'h3C;
    vdp_stall = 1'b1;
    cpu_access(1'b0, 2'd0, 8'h01, w);
    cpu_access(1'b0, 2'd1, 8'h02, w);
    cpu_access(1'b0, 2'd0, 8'h03, w);
    vdp_stall = 1'b0;
    cpu_access(1'b1, 2'd2, 8'h00, w);
    check("read_stall_cycles", 16'(w), 16'd11);
    check("read_strobe", {12'd0, vdp_read, vdp_write, vdp_mode}, {12'd0, 1'b1, 1'b0, 2'd2});
    cpu_rw = 1'b0; cpu_addr = 2'd0;
    #1;
    check("pend_write_rdy", {15'd0, cpu_rdy}, 16'd0);
    cpu_rw = 1'b1; cpu_addr = 2'd3;
    #1;
    check("pend_status_rdy", {15'd0, cpu_rdy}, 16'd1);
    tick();
    check("read_data", {6'd0, vdp_read, cpu_rvalid, cpu_rdata}, {6'd0, 1'b0, 1'b1, 8'h3C});
    tick();
    check("read_rvalid_end", {15'd0, cpu_rvalid}, 16'd0);

    // Reset during ASSERT with three entries queued
    vdp_stall = 1'b1;
    cpu_access(1'b0, 2'd2, 8'h51, w);
    cpu_access(1'b0, 2'd2, 8'h52, w);
    cpu_access(1'b0, 2'd2, 8'h53, w);
    cpu_access(1'b0, 2'd2, 8'h54, w);
    check("pre_reset_write", {15'd0, vdp_write}, 16'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vdp_stall = 1'b0;
    check("reset_drop", {4'd0, vdp_write, vdp_read, vdp_mode, vdp_wdata}, 16'd0);
    check("reset_cpu_side", {7'd0, cpu_rvalid, cpu_rdata}, 16'd0);
    cpu_access(1'b1, 2'd3, 8'h00, w);
    check("status_after_reset", {7'd0, cpu_rvalid, cpu_rdata}, {7'd0, 1'b1, 8'h40});
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (vdp_write !== 1'b0) ok = 1'b0;
      tick();
    end
    check("flushed_no_issue", {15'd0, ok}, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
